spi_arbiter: RTL and testbench
==============================

# spi_arbiter

Shares the single SPI master between two requesters: requester 0 is the host command configurator, and requester 1 is the front-end calibration/trigger sequencer. The block captures each requester's one-cycle write strobe with its slave select and 16-bit frame, and serialises the frames onto the master. It holds the winning slave select until the master reports completion, then returns the read-back word and a done pulse to the owner. It sits between the command/config logic and the SPI master, and is the only driver of `wrt_SPI`, `ss` and `SPI_data`.

## Interface
- No parameters. Frame width is fixed at 16 and slave select at 3 bits.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_wrt`, `req1_wrt` in 1: one-cycle transfer request strobes.
- `req0_ss`, `req1_ss` in 3: requested slave select, sampled with the strobe. Active-low one-cold; 3'b111 means none.
- `req0_data`, `req1_data` in 16: frame to send, sampled with the strobe.
- `req0_busy`, `req1_busy` out 1: request pending or in flight.
- `req0_done`, `req1_done` out 1: one-cycle completion pulse.
- `req0_rd_data`, `req1_rd_data` out 16: read-back word, held until that requester's next completion.
- `wrt_SPI` out 1: one-cycle start strobe to the SPI master.
- `ss` out 3: slave select to the SPI master.
- `SPI_data` out 16: frame to the SPI master.
- `SPI_done` in 1: master completion (level or pulse).
- `SPI_rd_data` in 16: master shift-in word, valid when `SPI_done` is high.

## Operation
- Per requester there is a pending flag with latched ss/data.
  - `reqN_wrt` while `reqN_busy`=0: set pend, latch ss/data.
  - `reqN_wrt` while busy: ignored, and the latched values are unchanged.
- `reqN_busy` equals pend. Pend clears on the edge that completes that requester's transfer.
- FSM states are IDLE, LAUNCH and XFER.
  - IDLE: if any pend is set, pick the owner, load `ss`/`SPI_data` from the owner's latch, and go to LAUNCH. Otherwise stay.
  - LAUNCH: `wrt_SPI`=1 for exactly this one cycle, then go to XFER.
  - XFER: hold `ss`/`SPI_data`. When `SPI_done` is sampled high: capture `SPI_rd_data` into `reqN_rd_data` of the owner, pulse `reqN_done`, clear the owner's pend, set `ss`=3'b111, and go to IDLE.
- `SPI_done` is ignored in IDLE and LAUNCH. The FSM does not enter XFER before wrt has been issued.
- Outside LAUNCH/XFER: `ss`=3'b111 and `SPI_data`=16'h0000.
- All outputs are registered.
- An illegal requested ss (any value) is passed through unmodified. Decoding it is the requester's responsibility.

## Timing
- Reset values:
  - state IDLE, pends 0, `wrt_SPI` 0, `ss` 3'b111, `SPI_data` 0.
  - `reqN_busy`/`reqN_done` 0, `reqN_rd_data` 0, last-grant = 1.
- Uncontended latency:
  - Strobe sampled at edge E0; `busy` is high after E0.
  - Grant at E1; `wrt_SPI` is high for the cycle E1–E2.
  - `SPI_done` sampled at Ed; after Ed, `reqN_done`=1 for one cycle, `rd_data` is valid, and `busy`=0.
- A requester may strobe again in the cycle its `done` is high. That strobe is accepted.
- Back-to-back transfers: if the other pend is set at Ed, the FSM is in IDLE after Ed, grants at Ed+1, and `wrt_SPI` is high after Ed+1. There is at least one idle cycle with `ss`=3'b111 between frames.
- Both strobes on the same edge are both latched. Arbitration then follows Configuration.
- `SPI_done` and a new strobe on the same edge: both are acted on.
- Reset mid-transfer drops all pends without a done pulse. `ss` returns to 3'b111 immediately (asynchronous).

## Configuration
- `SPI_ARB_RR_EN` defined: round-robin arbitration.
  - When both are pending, grant the requester not granted last.
  - Last-grant updates on each grant. Reset value 1 means requester 0 wins first.
- `SPI_ARB_RR_EN` undefined: fixed priority, requester 0 always wins. The last-grant register is not built.

## Test plan
- Single request: req0 strobe with ss=3'b011, data=16'h1328; `SPI_done` with `SPI_rd_data`=16'hA55A 5 cycles after `wrt_SPI`.
  - `wrt_SPI` is high exactly 1 cycle, 2 clocks after the strobe.
  - `ss`=3'b011 is held until done.
  - `req0_done` pulses once, with `req0_rd_data`=16'hA55A.
- Simultaneous strobes: req0 data=16'h1302 and req1 data=16'h13C9 on the same edge.
  - With RR: req0 goes first; then on a repeat with both pending again, req1 goes first.
  - Without the macro: req0 goes first on both repeats.
  - No overlap of `ss` ≠ 3'b111 between frames.
- Busy drop: req1 strobes 16'h4001 and then, while busy, strobes 16'h4002 → only 16'h4001 reaches `SPI_data`.
- Early done: `SPI_done` high in IDLE and during LAUNCH → ignored, with no done pulse.
- Re-strobe on done: req0 strobes again in the cycle `req0_done`=1 → the second frame is launched.
- Reset during XFER: `ss` goes to 3'b111 at once, and there is no `reqN_done` after reset release.

Source files
------------

// File: rtl/spi_arbiter.sv
// -----------------------------------------------------------------------------
// spi_arbiter
// Shares one SPI master between two requesters: requester 0 is the host
// command configurator and requester 1 is the front-end calibration/trigger
// sequencer. Each requester's strobe, slave select and frame are latched into
// a pending slot. The slots are then serialised onto the master one at a time.
// The winning slave select is held until the master reports completion, and
// the read-back word is then returned to the owner with a one-cycle done pulse.
//
// Build option:
//   SPI_ARB_RR_EN  defined   -> round-robin arbitration (a last-grant register
//                               is built, reset value 1 so requester 0 wins first)
//                  undefined -> fixed priority, requester 0 always wins
//
// Ports:
//   clk, rst_n                     clock (rising edge), async active-low reset
//   req0_wrt/req1_wrt        in    one-cycle transfer request strobes
//   req0_ss/req1_ss          in    [2:0] requested slave select (active-low)
//   req0_data/req1_data      in    [15:0] frame to send
//   req0_busy/req1_busy      out   request pending or in flight
//   req0_done/req1_done      out   one-cycle completion pulse
//   req0_rd_data/req1_rd_data out  [15:0] read-back word of last completion
//   wrt_SPI                  out   one-cycle start strobe to the SPI master
//   ss                       out   [2:0] slave select to the SPI master
//   SPI_data                 out   [15:0] frame to the SPI master
//   SPI_done                 in    master completion (level or pulse)
//   SPI_rd_data              in    [15:0] master shift-in word
// -----------------------------------------------------------------------------
module spi_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_wrt,
   input  logic [2:0]  req0_ss,
   input  logic [15:0] req0_data,
   input  logic        req1_wrt,
   input  logic [2:0]  req1_ss,
   input  logic [15:0] req1_data,
   output logic        req0_busy,
   output logic        req0_done,
   output logic [15:0] req0_rd_data,
   output logic        req1_busy,
   output logic        req1_done,
   output logic [15:0] req1_rd_data,
   output logic        wrt_SPI,
   output logic [2:0]  ss,
   output logic [15:0] SPI_data,
   input  logic        SPI_done,
   input  logic [15:0] SPI_rd_data
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_XFER   = 2'd2;

   localparam logic [2:0]  SS_NONE   = 3'b111;
   localparam logic [15:0] DATA_NONE = 16'h0000;

   logic [1:0]  r_state;
   logic        r_pend0;
   logic        r_pend1;
   logic [2:0]  r_ss0;
   logic [2:0]  r_ss1;
   logic [15:0] r_data0;
   logic [15:0] r_data1;
   logic        r_owner;      // requester that owns the current frame
   logic        r_wrt;
   logic [2:0]  r_ss;
   logic [15:0] r_spi_data;
   logic        r_done0;
   logic        r_done1;
   logic [15:0] r_rd0;
   logic [15:0] r_rd1;
`ifdef SPI_ARB_RR_EN
   logic        r_last;       // requester granted most recently
`endif

   logic        w_grant;
   logic        w_grant_id;
   logic        w_complete;

   // Grant decision, evaluated only while the FSM is idle
   always_comb begin
      w_grant = (r_state == ST_IDLE) && (r_pend0 || r_pend1);
      if (r_pend0 && r_pend1) begin
`ifdef SPI_ARB_RR_EN
         w_grant_id = ~r_last;
`else
         w_grant_id = 1'b0;
`endif
      end else if (r_pend1) begin
         w_grant_id = 1'b1;
      end else begin
         w_grant_id = 1'b0;
      end
   end

   // SPI_done only counts once the start strobe has gone out
   assign w_complete = (r_state == ST_XFER) && SPI_done;

   // Requester 0 pending slot: strobes while busy are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend0 <= 1'b0;
         r_ss0   <= SS_NONE;
         r_data0 <= DATA_NONE;
      end else if (req0_wrt && !r_pend0) begin
         r_pend0 <= 1'b1;
         r_ss0   <= req0_ss;
         r_data0 <= req0_data;
      end else if (w_complete && (r_owner == 1'b0)) begin
         r_pend0 <= 1'b0;
      end else begin
         r_pend0 <= r_pend0;
      end
   end

   // Requester 1 pending slot: strobes while busy are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend1 <= 1'b0;
         r_ss1   <= SS_NONE;
         r_data1 <= DATA_NONE;
      end else if (req1_wrt && !r_pend1) begin
         r_pend1 <= 1'b1;
         r_ss1   <= req1_ss;
         r_data1 <= req1_data;
      end else if (w_complete && (r_owner == 1'b1)) begin
         r_pend1 <= 1'b0;
      end else begin
         r_pend1 <= r_pend1;
      end
   end

   // Transfer sequencer driving the SPI master interface
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_owner    <= 1'b0;
         r_wrt      <= 1'b0;
         r_ss       <= SS_NONE;
         r_spi_data <= DATA_NONE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant) begin
                  r_state    <= ST_LAUNCH;
                  r_owner    <= w_grant_id;
                  r_wrt      <= 1'b1;
                  r_ss       <= w_grant_id ? r_ss1 : r_ss0;
                  r_spi_data <= w_grant_id ? r_data1 : r_data0;
               end else begin
                  r_state    <= ST_IDLE;
                  r_wrt      <= 1'b0;
                  r_ss       <= SS_NONE;
                  r_spi_data <= DATA_NONE;
               end
            end
            ST_LAUNCH: begin
               r_wrt   <= 1'b0;
               r_state <= ST_XFER;
            end
            ST_XFER: begin
               r_wrt <= 1'b0;
               if (SPI_done) begin
                  r_state    <= ST_IDLE;
                  r_ss       <= SS_NONE;
                  r_spi_data <= DATA_NONE;
               end else begin
                  r_state <= ST_XFER;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_wrt      <= 1'b0;
               r_ss       <= SS_NONE;
               r_spi_data <= DATA_NONE;
            end
         endcase
      end
   end

   // Completion pulses and read-back capture for the owning requester
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         r_rd0   <= 16'h0000;
         r_rd1   <= 16'h0000;
      end else begin
         r_done0 <= w_complete && (r_owner == 1'b0);
         r_done1 <= w_complete && (r_owner == 1'b1);
         if (w_complete && (r_owner == 1'b0)) begin
            r_rd0 <= SPI_rd_data;
         end else begin
            r_rd0 <= r_rd0;
         end
         if (w_complete && (r_owner == 1'b1)) begin
            r_rd1 <= SPI_rd_data;
         end else begin
            r_rd1 <= r_rd1;
         end
      end
   end

`ifdef SPI_ARB_RR_EN
   // Last-grant memory; reset to 1 so requester 0 wins the first contest
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= 1'b1;
      end else if (w_grant) begin
         r_last <= w_grant_id;
      end else begin
         r_last <= r_last;
      end
   end
`endif

   assign req0_busy    = r_pend0;
   assign req1_busy    = r_pend1;
   assign req0_done    = r_done0;
   assign req1_done    = r_done1;
   assign req0_rd_data = r_rd0;
   assign req1_rd_data = r_rd1;
   assign wrt_SPI      = r_wrt;
   assign ss           = r_ss;
   assign SPI_data     = r_spi_data;

endmodule

// File: tb/tb_spi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_arbiter
// Directed and randomized bench for spi_arbiter. A small SPI master model
// answers every start strobe after a programmable delay. Expected frames,
// ownership and read-back words come from a transaction-level model: two
// pending slots plus the arbitration rule (round-robin when SPI_ARB_RR_EN is
// defined, otherwise requester 0 first).
// -----------------------------------------------------------------------------
module tb_spi_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0_wrt, req1_wrt;
   logic [2:0]  req0_ss, req1_ss;
   logic [15:0] req0_data, req1_data;
   logic        req0_busy, req1_busy, req0_done, req1_done;
   logic [15:0] req0_rd_data, req1_rd_data;
   logic        wrt_SPI;
   logic [2:0]  ss;
   logic [15:0] SPI_data;
   logic        SPI_done;
   logic [15:0] SPI_rd_data;

   // SPI master model controls
   logic        m_done;
   logic [15:0] m_rd;
   logic [15:0] m_last_rd;
   logic [15:0] m_rd_next;
   bit          m_fixed;
   int          m_dly;
   logic        early_done;
   logic [15:0] early_rd;

   // Transaction-level reference model
   bit          mp   [2];
   logic [2:0]  mss  [2];
   logic [15:0] mdat [2];
   logic [15:0] mrd  [2];
   int          mlast;

   int errors;
   int checks;

   assign SPI_done    = m_done | early_done;
   assign SPI_rd_data = m_done ? m_rd : early_rd;

   spi_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0_wrt     (req0_wrt),
      .req0_ss      (req0_ss),
      .req0_data    (req0_data),
      .req1_wrt     (req1_wrt),
      .req1_ss      (req1_ss),
      .req1_data    (req1_data),
      .req0_busy    (req0_busy),
      .req0_done    (req0_done),
      .req0_rd_data (req0_rd_data),
      .req1_busy    (req1_busy),
      .req1_done    (req1_done),
      .req1_rd_data (req1_rd_data),
      .wrt_SPI      (wrt_SPI),
      .ss           (ss),
      .SPI_data     (SPI_data),
      .SPI_done     (SPI_done),
      .SPI_rd_data  (SPI_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SPI master: answers each start strobe m_dly cycles later with a done pulse
   always begin
      @(negedge clk);
      if (wrt_SPI === 1'b1) begin
         repeat (m_dly) @(negedge clk);
         m_rd      = m_fixed ? m_rd_next : 16'($urandom);
         m_last_rd = m_rd;
         m_done    = 1'b1;
         @(negedge clk);
         m_done    = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic int pick();
      if (mp[0] && mp[1]) begin
`ifdef SPI_ARB_RR_EN
         return (mlast == 1) ? 0 : 1;
`else
         return 0;
`endif
      end
      if (mp[1]) return 1;
      return 0;
   endfunction

   task automatic model_reset();
      mp[0] = 1'b0;  mp[1] = 1'b0;
      mrd[0] = 16'h0000; mrd[1] = 16'h0000;
      mlast = 1;
   endtask

   task automatic check_reset_state();
      chk("rst_ss",    32'(ss),           32'h7);
      chk("rst_data",  32'(SPI_data),     32'h0);
      chk("rst_wrt",   32'(wrt_SPI),      32'h0);
      chk("rst_busy0", 32'(req0_busy),    32'h0);
      chk("rst_busy1", 32'(req1_busy),    32'h0);
      chk("rst_done0", 32'(req0_done),    32'h0);
      chk("rst_done1", 32'(req1_done),    32'h0);
      chk("rst_rd0",   32'(req0_rd_data), 32'h0);
      chk("rst_rd1",   32'(req1_rd_data), 32'h0);
   endtask

   // Present strobes for one cycle; the model latches only non-busy requesters
   task automatic strobe(input bit s0, input bit s1,
                         input logic [2:0] ss0, input logic [15:0] d0,
                         input logic [2:0] ss1, input logic [15:0] d1);
      req0_wrt = s0; req0_ss = ss0; req0_data = d0;
      req1_wrt = s1; req1_ss = ss1; req1_data = d1;
      if (s0 && !mp[0]) begin mp[0] = 1'b1; mss[0] = ss0; mdat[0] = d0; end
      if (s1 && !mp[1]) begin mp[1] = 1'b1; mss[1] = ss1; mdat[1] = d1; end
      step();
      req0_wrt = 1'b0;
      req1_wrt = 1'b0;
      chk("busy0", 32'(req0_busy), 32'(mp[0]));
      chk("busy1", 32'(req1_busy), 32'(mp[1]));
   endtask

   // Wait for the start strobe of requester r's frame and check it
   task automatic wait_launch(input int r, input int exp_wait);
      int n = 0;
      while (wrt_SPI !== 1'b1 && n < 40) begin
         step();
         n++;
         if (wrt_SPI !== 1'b1) begin
            chk("gap_ss",    32'(ss),        32'h7);
            chk("gap_done0", 32'(req0_done), 32'h0);
            chk("gap_done1", 32'(req1_done), 32'h0);
         end
      end
      chk("launch_seen", 32'(wrt_SPI), 32'h1);
      if (exp_wait >= 0) chk("launch_latency", 32'(n), 32'(exp_wait));
      chk("launch_ss",   32'(ss),       32'(mss[r]));
      chk("launch_data", 32'(SPI_data), 32'(mdat[r]));
      chk("launch_busy", 32'((r == 1) ? req1_busy : req0_busy), 32'h1);
      mlast = r;
   endtask

   // Wait for requester r's done pulse, checking the held frame meanwhile
   task automatic wait_done(input int r, input int exp_cycles);
      int n = 0;
      bit seen = 1'b0;
      while (n < 60) begin
         step();
         n++;
         if (req0_done === 1'b1 || req1_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         chk("hold_ss",   32'(ss),       32'(mss[r]));
         chk("hold_data", 32'(SPI_data), 32'(mdat[r]));
         chk("wrt_once",  32'(wrt_SPI),  32'h0);
      end
      chk("done_seen", 32'(seen), 32'h1);
      if (exp_cycles >= 0) chk("xfer_cycles", 32'(n), 32'(exp_cycles));
      chk("done_owner", 32'((r == 1) ? req1_done : req0_done), 32'h1);
      chk("done_other", 32'((r == 1) ? req0_done : req1_done), 32'h0);
      chk("rd_owner",   32'((r == 1) ? req1_rd_data : req0_rd_data), 32'(m_last_rd));
      chk("rd_other",   32'((r == 1) ? req0_rd_data : req1_rd_data), 32'(mrd[1 - r]));
      chk("done_ss",    32'(ss),       32'h7);
      chk("done_data",  32'(SPI_data), 32'h0);
      chk("busy_clear", 32'((r == 1) ? req1_busy : req0_busy), 32'h0);
      mp[r]  = 1'b0;
      mrd[r] = m_last_rd;
   endtask

   // Serve every pending slot in model-predicted order
   task automatic drain(input int first_wait);
      int g = 0;
      int r;
      int w = first_wait;
      while ((mp[0] || mp[1]) && g < 4) begin
         r = pick();
         wait_launch(r, w);
         wait_done(r, m_dly + 1);
         w = 1;
         g++;
      end
   endtask

   task automatic quiet(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         step();
         chk("quiet_wrt",   32'(wrt_SPI),   32'h0);
         chk("quiet_done0", 32'(req0_done), 32'h0);
         chk("quiet_done1", 32'(req1_done), 32'h0);
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (2) step();
      check_reset_state();
      rst_n = 1'b1;
      model_reset();
      step();
   endtask

   initial begin
      errors = 0; checks = 0;
      rst_n = 1'b0;
      req0_wrt = 1'b0; req1_wrt = 1'b0;
      req0_ss = 3'b111; req1_ss = 3'b111;
      req0_data = 16'h0000; req1_data = 16'h0000;
      m_done = 1'b0; m_rd = 16'h0000; m_last_rd = 16'h0000;
      m_rd_next = 16'h0000; m_fixed = 1'b1; m_dly = 5;
      early_done = 1'b0; early_rd = 16'h0000;
      model_reset();
      apply_reset();

      // Single request with exact latency
      m_dly = 5; m_fixed = 1'b1; m_rd_next = 16'hA55A;
      strobe(1'b1, 1'b0, 3'b011, 16'h1328, 3'b111, 16'h0000);
      wait_launch(0, 1);
      wait_done(0, 6);
      chk("single_rd", 32'(req0_rd_data), 32'h0000A55A);
      quiet(3);

      // Simultaneous strobes from reset, then a lone req0, then both again
      apply_reset();
      m_dly = 3; m_fixed = 1'b0;
      strobe(1'b1, 1'b1, 3'b110, 16'h1302, 3'b101, 16'h13C9);
      drain(1);
      strobe(1'b1, 1'b0, 3'b011, 16'h2000, 3'b111, 16'h0000);
      drain(1);
      strobe(1'b1, 1'b1, 3'b110, 16'h1302, 3'b101, 16'h13C9);
      drain(1);
      quiet(2);

      // Second strobe while busy is dropped
      m_dly = 3;
      strobe(1'b0, 1'b1, 3'b111, 16'h0000, 3'b011, 16'h4001);
      strobe(1'b0, 1'b1, 3'b111, 16'h0000, 3'b110, 16'h4002);
      drain(0);
      quiet(5);

      // SPI_done high in IDLE and LAUNCH is ignored
      m_dly = 4; early_rd = 16'hDEAD; early_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("early_idle_done0", 32'(req0_done), 32'h0);
         chk("early_idle_done1", 32'(req1_done), 32'h0);
         chk("early_idle_wrt",   32'(wrt_SPI),   32'h0);
      end
      strobe(1'b1, 1'b0, 3'b101, 16'h0F0F, 3'b111, 16'h0000);
      wait_launch(0, 1);
      chk("early_launch_done0", 32'(req0_done), 32'h0);
      step();
      chk("early_xfer_done0", 32'(req0_done), 32'h0);
      chk("early_xfer_ss",    32'(ss),        32'h5);
      early_done = 1'b0;
      wait_done(0, 4);

      // Re-strobe in the done cycle is accepted and launched
      m_dly = 2;
      strobe(1'b1, 1'b0, 3'b110, 16'h5A5A, 3'b111, 16'h0000);
      wait_launch(0, 1);
      wait_done(0, 3);
      strobe(1'b1, 1'b0, 3'b101, 16'h7E81, 3'b111, 16'h0000);
      wait_launch(0, 1);
      wait_done(0, 3);
      quiet(2);

      // Reset during XFER: ss released at once, no done afterwards
      m_dly = 6;
      strobe(1'b0, 1'b1, 3'b111, 16'h0000, 3'b110, 16'hBEEF);
      wait_launch(1, 1);
      step(); step();
      chk("xfer_ss_before_rst", 32'(ss), 32'h6);
      rst_n = 1'b0;
      #1;
      chk("async_rst_ss",    32'(ss),        32'h7);
      chk("async_rst_data",  32'(SPI_data),  32'h0);
      chk("async_rst_busy1", 32'(req1_busy), 32'h0);
      step(); step();
      rst_n = 1'b1;
      model_reset();
      quiet(12);

      // Randomized contention, data and master delay
      for (int it = 0; it < 30; it++) begin
         int kind;
         int w;
         logic [2:0]  a_ss, b_ss;
         logic [15:0] a_d, b_d;
         kind = $urandom_range(1, 3);
         m_dly = $urandom_range(1, 6);
         a_ss = 3'($urandom); b_ss = 3'($urandom);
         a_d = 16'($urandom); b_d = 16'($urandom);
         strobe(kind[0], kind[1], a_ss, a_d, b_ss, b_d);
         w = 1;
         if ($urandom_range(0, 1) == 1) begin
            strobe(kind[0], kind[1], ~a_ss, ~a_d, ~b_ss, ~b_d);
            w = 0;
         end
         drain(w);
      end
      quiet(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
